// File: rtl/funnyarch_bus_pkg.sv
// rtl/funnyarch_bus_pkg.sv - address map, STATUS layout and UART state encoding
package funnyarch_bus_pkg;

    localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_0000;
    localparam logic [31:0] ADDR_STATUS = 32'hFFFF_0004;
    localparam logic [31:0] ADDR_TIMER  = 32'hFFFF_0008;

    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO feeding an 8N1 UART serializer
module uart_tx_fifo
    import funnyarch_bus_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       ovf_clr_i,
    output logic       full_o,
    output logic [3:0] count_o,
    output logic       busy_o,
    output logic       overflow_o,
    output logic       uart_tx_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    COUNT_FULL = 4'(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [3:0]    count_q, count_d;
    logic          overflow_q, overflow_d;
    uart_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          pop, push_ok, baud_done;

    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign full_o    = (count_q == COUNT_FULL);
    assign pop       = (state_q == UART_IDLE) && (count_q != 4'd0);
    assign push_ok   = push_i && (!full_o || pop);
    assign baud_done = (baud_q == BAUD_LAST);

    assign count_o    = count_q;
    assign busy_o     = (count_q != 4'd0) || (state_q != UART_IDLE);
    assign overflow_o = overflow_q;
    assign uart_tx_o  = tx_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= UART_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
        end
    end

    // An overflowing push outranks a simultaneous clear.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + PW'(push_ok);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + 4'(push_ok) - 4'(pop);
        overflow_d = overflow_q;
        if (ovf_clr_i) begin
            overflow_d = 1'b0;
        end
        if (push_i && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            UART_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    state_d = UART_START;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            UART_START: begin
                if (baud_done) begin
                    state_d = UART_DATA;
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            UART_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = UART_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            UART_STOP: begin
                if (baud_done) begin
                    state_d = UART_IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = UART_IDLE;
        endcase
    end

endmodule

// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - zero-wait CPU bus slave: RAM, UART TX, STATUS and free-running TIMER
module bus_responder
    import funnyarch_bus_pkg::*;
#(
    parameter int RAM_WORDS    = 4096,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic        data_rw,
    output logic [31:0] data_out,
    output logic        uart_tx
);
    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]   ram_q [RAM_WORDS];
    logic [31:0]   timer_q, timer_d;
    logic [AW-1:0] ram_idx;
    logic          sel_ram, sel_tx, sel_status, sel_timer;
    logic          fifo_full, fifo_busy, fifo_ovf;
    logic [3:0]    fifo_count;
    logic [31:0]   status_word;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^address[1:0];

    assign ram_idx    = address[AW+1:2];
    assign sel_ram    = (address[31:AW+2] == '0);
    assign sel_tx     = (address[31:2] == ADDR_TXDATA[31:2]);
    assign sel_status = (address[31:2] == ADDR_STATUS[31:2]);
    assign sel_timer  = (address[31:2] == ADDR_TIMER[31:2]);

    uart_tx_fifo #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_uart (
        .clk       (clk),
        .reset     (reset),
        .push_i    (data_rw && sel_tx),
        .data_i    (data_in[7:0]),
        .ovf_clr_i (data_rw && sel_status && data_in[STATUS_OVF_BIT]),
        .full_o    (fifo_full),
        .count_o   (fifo_count),
        .busy_o    (fifo_busy),
        .overflow_o(fifo_ovf),
        .uart_tx_o (uart_tx)
    );

    // RAM is deliberately not reset so software state survives a bus reset.
    always_ff @(posedge clk) begin
        if (data_rw && sel_ram) begin
            ram_q[ram_idx] <= data_in;
        end
    end

    always_comb begin
        timer_d = timer_q + 32'd1;
        if (data_rw && sel_timer) begin
            timer_d = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    always_comb begin
        status_word                             = '0;
        status_word[STATUS_BUSY_BIT]            = fifo_busy;
        status_word[STATUS_FULL_BIT]            = fifo_full;
        status_word[STATUS_OVF_BIT]             = fifo_ovf;
        status_word[STATUS_COUNT_LSB +: 4]      = fifo_count;
    end

    always_comb begin
        data_out = '0;
        if (sel_ram) begin
            data_out = ram_q[ram_idx];
        end else if (sel_status) begin
            data_out = status_word;
        end else if (sel_timer) begin
            data_out = timer_q;
        end
    end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter RAM_WORDS, default 4096, RAM depth in 32-bit words (power of two, max 4096).
REQ-002 Parameter CLKS_PER_BIT, default 868, UART bit period in clk cycles (>=2).
REQ-003 Parameter FIFO_DEPTH, default 8, UART TX FIFO entries (power of two, <=8).
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 address  input  32  CPU byte address; bits [1:0] ignored.
REQ-007 data_in  input  32  write data from CPU.
REQ-008 data_rw  input  1  1 = write this cycle, 0 = read.
REQ-009 data_out  output  32  read data to CPU.
REQ-010 uart_tx  output  1  serial line, 8N1, idle high.

Function
REQ-011 The block SHALL decode: RAM at 0x0000_0000..RAM_WORDS*4-1, TXDATA at 0xFFFF_0000, STATUS at 0xFFFF_0004, TIMER at 0xFFFF_0008; all else unmapped.
REQ-012 data_out SHALL be combinational from address and current state (zero wait states): RAM word, STATUS, or TIMER; TXDATA and unmapped read 0x0000_0000.
REQ-013 Reads SHALL have no side effects.
REQ-014 With data_rw=1 at a rising edge, the block SHALL commit data_in to the decoded target at that edge; unmapped writes ignored.
REQ-015 RAM index SHALL be address[log2(RAM_WORDS)+1:2]; RAM read-after-write SHALL return the new word in the following cycle.
REQ-016 A TXDATA write SHALL push data_in[7:0] into the FIFO; push when full SHALL be dropped and set sticky overflow, unless a pop occurs the same edge, in which case the push SHALL be accepted.
REQ-017 STATUS bits: [0] tx_busy (FIFO non-empty or FSM not IDLE), [1] fifo_full, [2] overflow, [7:4] FIFO count (0..FIFO_DEPTH), others 0.
REQ-018 STATUS write with data_in[2]=1 SHALL clear overflow; a simultaneous overflowing push SHALL win (overflow stays 1).
REQ-019 TIMER SHALL increment by 1 every cycle, wrapping 0xFFFF_FFFF->0; a TIMER write SHALL load data_in, incrementing from the following cycle.
REQ-020 UART FSM states IDLE, START, DATA, STOP; IDLE with FIFO non-empty SHALL pop one byte and enter START at the same edge.
REQ-021 uart_tx SHALL be registered: 0 for START, data bits LSB first in DATA, 1 in STOP and IDLE; each bit exactly CLKS_PER_BIT cycles.
REQ-022 After STOP, FSM SHALL return to IDLE and pop a waiting byte the next cycle, giving a frame-to-frame gap of one idle cycle.
REQ-023 FIFO SHALL use wrapping read/write pointers with a separate count; no pop when empty, no bypass of an empty FIFO.

Reset
REQ-024 On reset: uart_tx=1, FSM=IDLE, FIFO empty (count 0), overflow=0, TIMER=0, baud and bit counters=0.
REQ-025 Reset mid-frame SHALL abort the frame and drive uart_tx=1 the cycle after the reset edge; queued bytes are discarded.
REQ-026 RAM contents SHALL NOT be cleared by reset.

Structure
REQ-027 Package funnyarch_bus_pkg SHALL hold address-map constants, STATUS bit indices and the UART state encoding.
REQ-028 FIFO plus serializer SHALL be sub-module uart_tx_fifo (push/data/full/count in, uart_tx out); RAM, decode and TIMER stay in bus_responder.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-029 Write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> 0xDEADBEEF next cycle; read 0x0000_0014 unchanged; read 0x1000_0000 -> 0.
REQ-030 Write 0x55 to TXDATA -> uart_tx low 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, high 4 cycles; STATUS[0] = 1 throughout, 0 after.
REQ-031 Nine TXDATA writes back-to-back from idle -> first popped at once, eight queued, STATUS=0x83 (count 8, full, busy); tenth write -> STATUS[2]=1; STATUS write 0x4 -> STATUS[2]=0.
REQ-032 Nine bytes 0x01..0x09 queued -> nine frames emitted in order, one idle cycle between frames, no loss.
REQ-033 Write 0xFFFF_FFFE to TIMER -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on following cycles.
REQ-034 Reset asserted during DATA of byte 0xA5 with two bytes queued -> uart_tx=1, STATUS=0, no further frames; RAM word at 0x10 retained.
